// File: rtl/pulse_meter_pkg.sv
// Shared types and constants for the multi-channel pulse/period meter.
package pulse_meter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } meter_state_e;

  localparam logic MODE_HIGH   = 1'b0;
  localparam logic MODE_PERIOD = 1'b1;

  localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/pulse_meter_ch.sv
// One measurement channel: edge detect, IDLE/COUNT FSM, saturating counter,
// result capture and valid/ack handshake with overrun tracking.
module pulse_meter_ch
  import pulse_meter_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             mode_chg,
  input  logic             in_sig,
  input  logic             ack,
  output logic [CNT_W-1:0] duration,
  output logic             valid,
  output logic             ovf,
  output logic             overrun
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  meter_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0] dur_q, dur_d;
  logic             prev_q, prev_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             overrun_q, overrun_d;
  logic             rise, fall, capture;

  // Edge detect and measurement FSM
  always_comb begin
    prev_d  = in_sig;
    rise    = ~prev_q & in_sig;
    fall    = prev_q & ~in_sig;
    cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    if (!en || mode_chg) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rise) begin
            state_d = COUNT;
            cnt_d   = CNT_W'(1);
          end
        end
        COUNT: begin
          if (mode == MODE_PERIOD) begin
            if (rise) begin
              capture = 1'b1;
              cnt_d   = CNT_W'(1);
            end else begin
              cnt_d = cnt_inc;
            end
          end else if (fall) begin
            capture = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
          end else if (in_sig) begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Result register and handshake; a capture always wins over a plain ack
  always_comb begin
    dur_d     = dur_q;
    valid_d   = valid_q;
    ovf_d     = ovf_q;
    overrun_d = overrun_q;
    if (capture) begin
      dur_d   = cnt_q;
      valid_d = 1'b1;
      ovf_d   = (cnt_q == CNT_MAX);
      if (ack)          overrun_d = 1'b0;
      else if (valid_q) overrun_d = 1'b1;
    end else if (ack && valid_q) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
  end

  // History resets high so a level already high at reset is not a rise
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q    <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      dur_q     <= '0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      prev_q    <= prev_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dur_q     <= dur_d;
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
      overrun_q <= overrun_d;
    end
  end

  assign duration = dur_q;
  assign valid    = valid_q;
  assign ovf      = ovf_q;
  assign overrun  = overrun_q;

endmodule

// File: rtl/pulse_period_meter.sv
// Multi-channel high-time / period meter top. Optional input synchroniser
// enabled by defining SYNC_INPUT_EN (adds 2 RefClk cycles of latency).
module pulse_period_meter
  import pulse_meter_pkg::*;
#(
  parameter int CH    = 2,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                RefClk,
  input  logic                rst,
  input  logic                en,
  input  logic                mode,
  input  logic [CH-1:0]       InFreq,
  input  logic [CH-1:0]       ack,
  output logic [CH*CNT_W-1:0] duration,
  output logic [CH-1:0]       valid,
  output logic [CH-1:0]       ovf,
  output logic [CH-1:0]       overrun
);

  logic          mode_q, mode_d;
  logic          mode_chg;
  logic [CH-1:0] in_s;

  always_comb begin
    mode_d   = mode;
    mode_chg = (mode != mode_q);
  end

  always_ff @(posedge RefClk) begin
    if (rst) mode_q <= MODE_HIGH;
    else     mode_q <= mode_d;
  end

`ifdef SYNC_INPUT_EN
  logic [CH-1:0] sync1_q, sync1_d;
  logic [CH-1:0] sync2_q, sync2_d;

  always_comb begin
    sync1_d = InFreq;
    sync2_d = sync1_q;
  end

  // Reset high to match the edge-detect history and avoid a false rise
  always_ff @(posedge RefClk) begin
    if (rst) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign in_s = sync2_q;
`else
  assign in_s = InFreq;
`endif

  for (genvar gi = 0; gi < CH; gi++) begin : g_ch
    pulse_meter_ch #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk      (RefClk),
      .rst      (rst),
      .en       (en),
      .mode     (mode),
      .mode_chg (mode_chg),
      .in_sig   (in_s[gi]),
      .ack      (ack[gi]),
      .duration (duration[gi*CNT_W +: CNT_W]),
      .valid    (valid[gi]),
      .ovf      (ovf[gi]),
      .overrun  (overrun[gi])
    );
  end

endmodule

// File: tb/tb_pulse_period_meter.sv
// Directed bench for pulse_period_meter: table-driven high-time vectors plus
// hand-written period, saturation, overrun and disturbance sequences.
module tb_pulse_period_meter;

`ifdef SYNC_INPUT_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic        clk = 1'b0;
  logic        rst, en, mode;
  logic [1:0]  in_freq, ack;
  logic [31:0] dur;
  logic [1:0]  valid, ovf, overrun;
  logic [0:0]  in4, ack4;
  logic [3:0]  dur4;
  logic [0:0]  valid4, ovf4, overrun4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pulse_period_meter #(.CH(2), .CNT_W(16)) dut (
    .RefClk(clk), .rst(rst), .en(en), .mode(mode), .InFreq(in_freq), .ack(ack),
    .duration(dur), .valid(valid), .ovf(ovf), .overrun(overrun)
  );

  pulse_period_meter #(.CH(1), .CNT_W(4)) dut4 (
    .RefClk(clk), .rst(rst), .en(en), .mode(mode), .InFreq(in4), .ack(ack4),
    .duration(dur4), .valid(valid4), .ovf(ovf4), .overrun(overrun4)
  );

  typedef struct {
    int          ch;
    int          n;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // High for n cycles, then low; the following edge samples the fall
  task automatic pulse(input int ch, input int n);
    in_freq[ch] = 1'b1;
    repeat (n) tick();
    in_freq[ch] = 1'b0;
  endtask

  task automatic wait_valid(input int ch, output int k);
    k = 0;
    do begin
      tick();
      k++;
    end while (!valid[ch] && k < 20);
  endtask

  task automatic ack_ch(input int ch);
    ack[ch] = 1'b1;
    tick();
    ack[ch] = 1'b0;
  endtask

  initial begin
    int k;
    tbl[0] = '{ch: 0, n: 10, exp: 16'd10};
    tbl[1] = '{ch: 1, n: 1,  exp: 16'd1};
    tbl[2] = '{ch: 0, n: 3,  exp: 16'd3};
    tbl[3] = '{ch: 1, n: 17, exp: 16'd17};
    tbl[4] = '{ch: 0, n: 2,  exp: 16'd2};

    rst = 1'b1; en = 1'b1; mode = 1'b0;
    in_freq = 2'b10; ack = 2'b00; in4 = 1'b0; ack4 = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("reset_dur", dur, 32'd0);
    chk("reset_valid", {30'd0, valid}, 32'd0);
    chk("reset_ovf", {30'd0, ovf}, 32'd0);
    chk("reset_overrun", {30'd0, overrun}, 32'd0);

    // ch1 high through reset: its release must not produce a result
    repeat (5) tick();
    in_freq[1] = 1'b0;
    repeat (3 + LAT) tick();
    chk("high_at_reset_valid1", {31'd0, valid[1]}, 32'd0);

    // Table-driven high-time pulses
    for (int i = 0; i < 5; i++) begin
      int c;
      c = tbl[i].ch;
      pulse(c, tbl[i].n);
      wait_valid(c, k);
      chk($sformatf("vec%0d_latency", i), k, 1 + LAT);
      chk($sformatf("vec%0d_dur", i), {16'd0, dur[c*16 +: 16]}, {16'd0, tbl[i].exp});
      chk($sformatf("vec%0d_other_valid", i), {31'd0, valid[1-c]}, 32'd0);
      chk($sformatf("vec%0d_ovf", i), {31'd0, ovf[c]}, 32'd0);
      chk($sformatf("vec%0d_overrun", i), {31'd0, overrun[c]}, 32'd0);
      ack_ch(c);
      chk($sformatf("vec%0d_ack_valid", i), {31'd0, valid[c]}, 32'd0);
      chk($sformatf("vec%0d_dur_held", i), {16'd0, dur[c*16 +: 16]}, {16'd0, tbl[i].exp});
      tick();
    end

    // Period mode, square wave of period 25 on ch0
    mode = 1'b1;
    tick(); tick();
    for (int p = 0; p < 5; p++) begin
      in_freq[0] = 1'b1;
      repeat (1 + LAT) tick();
      if (p == 0) begin
        chk("period_first_no_result", {31'd0, valid[0]}, 32'd0);
      end else begin
        chk($sformatf("period%0d_dur", p), {16'd0, dur[15:0]}, 32'd25);
        chk($sformatf("period%0d_valid", p), {31'd0, valid[0]}, 32'd1);
        chk($sformatf("period%0d_overrun", p), {31'd0, overrun[0]}, 32'd0);
        ack_ch(0);
      end
      repeat (12 - 1 - LAT - ((p > 0) ? 1 : 0)) tick();
      in_freq[0] = 1'b0;
      repeat (13) tick();
    end
    mode = 1'b0;
    tick(); tick();

    // Saturation on a 4-bit counter, then a short pulse clears ovf
    in4 = 1'b1;
    repeat (20) tick();
    in4 = 1'b0;
    repeat (1 + LAT) tick();
    chk("sat_dur", {28'd0, dur4}, 32'd15);
    chk("sat_ovf", {31'd0, ovf4}, 32'd1);
    chk("sat_valid", {31'd0, valid4}, 32'd1);
    ack4 = 1'b1; tick(); ack4 = 1'b0;
    in4 = 1'b1;
    repeat (3) tick();
    in4 = 1'b0;
    repeat (1 + LAT) tick();
    chk("short_dur", {28'd0, dur4}, 32'd3);
    chk("short_ovf", {31'd0, ovf4}, 32'd0);
    ack4 = 1'b1; tick(); ack4 = 1'b0;

    // Overrun: two results without ack
    pulse(0, 5);
    repeat (1 + LAT) tick();
    chk("ovr_first_dur", {16'd0, dur[15:0]}, 32'd5);
    pulse(0, 7);
    repeat (1 + LAT) tick();
    chk("ovr_dur", {16'd0, dur[15:0]}, 32'd7);
    chk("ovr_overrun", {31'd0, overrun[0]}, 32'd1);
    ack_ch(0);
    chk("ovr_ack_valid", {31'd0, valid[0]}, 32'd0);
    chk("ovr_ack_overrun", {31'd0, overrun[0]}, 32'd0);
    pulse(0, 2);
    repeat (1 + LAT) tick();
    pulse(0, 9);
    repeat (1 + LAT) tick();
    chk("ovr2_overrun", {31'd0, overrun[0]}, 32'd1);
    // ack on the capture edge of the 4-cycle pulse
    pulse(0, 4);
    repeat (LAT) tick();
    ack[0] = 1'b1;
    tick();
    ack[0] = 1'b0;
    chk("cap_ack_dur", {16'd0, dur[15:0]}, 32'd4);
    chk("cap_ack_valid", {31'd0, valid[0]}, 32'd1);
    chk("cap_ack_overrun", {31'd0, overrun[0]}, 32'd0);
    ack_ch(0);
    tick();

    // Reset in cycle 6 of a high pulse
    in_freq[0] = 1'b1;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_dur", dur, 32'd0);
    chk("midrst_flags", {26'd0, valid, ovf, overrun}, 32'd0);
    repeat (2) tick();
    in_freq[0] = 1'b0;
    repeat (3 + LAT) tick();
    chk("midrst_no_result", {31'd0, valid[0]}, 32'd0);
    pulse(0, 6);
    wait_valid(0, k);
    chk("after_rst_dur", {16'd0, dur[15:0]}, 32'd6);
    ack_ch(0);
    tick();

    // Mode toggle mid-count aborts the measurement
    in_freq[0] = 1'b1;
    repeat (4) tick();
    mode = 1'b1; tick();
    mode = 1'b0; tick();
    repeat (3) tick();
    in_freq[0] = 1'b0;
    repeat (3 + LAT) tick();
    chk("mode_abort_valid", {31'd0, valid[0]}, 32'd0);
    chk("mode_abort_dur_held", {16'd0, dur[15:0]}, 32'd6);

    // en=0 mid-count aborts the measurement
    in_freq[0] = 1'b1;
    repeat (4) tick();
    en = 1'b0; tick();
    en = 1'b1;
    repeat (3) tick();
    in_freq[0] = 1'b0;
    repeat (3 + LAT) tick();
    chk("en_abort_valid", {31'd0, valid[0]}, 32'd0);
    chk("en_abort_dur_held", {16'd0, dur[15:0]}, 32'd6);

    // Simultaneous captures on both channels
    in_freq = 2'b11;
    repeat (8) tick();
    in_freq = 2'b00;
    repeat (1 + LAT) tick();
    chk("dual_dur", dur, {16'd8, 16'd8});
    chk("dual_valid", {30'd0, valid}, 32'd3);
    ack = 2'b11; tick(); ack = 2'b00;
    chk("dual_ack_valid", {30'd0, valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
